// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings for the multi-cycle multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] MD_MULU = 2'd0;
    localparam logic [1:0] MD_MULS = 2'd1;
    localparam logic [1:0] MD_DIVU = 2'd2;
    localparam logic [1:0] MD_DIVS = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_RUN_MUL = 2'd1,
        MD_RUN_DIV = 2'd2
    } md_state_e;

    function automatic int md_cnt_width(input int rv);
        return $clog2(rv);
    endfunction
endpackage

// File: rtl/muldiv_mstep.sv
// rtl/muldiv_mstep.sv - one multiply iteration: shift accumulator, add digit * |b|
module muldiv_mstep #(
    parameter int RV    = 32,
    parameter int MBITS = 1
) (
    input  logic [2*RV-1:0]  acc_i,
    input  logic [MBITS-1:0] digit_i,
    input  logic [RV-1:0]    bmag_i,
    output logic [2*RV-1:0]  acc_o
);
    logic [RV+MBITS-1:0] pp;

    assign pp    = {{RV{1'b0}}, digit_i} * {{MBITS{1'b0}}, bmag_i};
    assign acc_o = (acc_i << MBITS) + {{(RV-MBITS){1'b0}}, pp};
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply / restoring divide with abort and hi/lo results
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int RV    = 32,
    parameter int MBITS = 1,
    parameter int DIV   = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    input  logic          abort,
    input  logic          hi_we,
    input  logic [RV-1:0] hi_wdata,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] lo,
    output logic [RV-1:0] hi
);
    localparam int            CW       = md_cnt_width(RV);
    localparam logic [CW-1:0] MUL_LAST = CW'(RV / MBITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(RV - 1);
    localparam logic [RV-1:0] MOST_NEG = {1'b1, {(RV-1){1'b0}}};

    md_state_e       state_q;
    logic            busy_q, done_q, neg_q, rneg_q;
    logic [CW-1:0]   cnt_q;
    logic [RV-1:0]   lo_q, hi_q, opa_q, opb_q, rem_q;
    logic [2*RV-1:0] acc_q;

    logic            is_div, is_signed, a_neg, b_neg, accept, special, fits;
    logic [RV-1:0]   a_abs, b_abs, spec_lo, spec_hi;
    logic [RV-1:0]   rem_d, quo_d, quo_fin, rem_fin;
    logic [RV:0]     rem_sh, rem_sub;
    logic [2*RV-1:0] acc_d, mul_res;

    assign is_div    = (op == MD_DIVU) || (op == MD_DIVS);
    assign is_signed = (op == MD_MULS) || (op == MD_DIVS);
    assign a_neg     = is_signed && a[RV-1];
    assign b_neg     = is_signed && b[RV-1];
    assign a_abs     = a_neg ? -a : a;
    assign b_abs     = b_neg ? -b : b;
    assign accept    = start && !busy_q && !abort;

    always_comb begin
        special = 1'b0;
        spec_lo = '0;
        spec_hi = '0;
        if (is_div) begin
            if (DIV == 0) begin
                special = 1'b1;
            end else if (b == '0) begin
                special = 1'b1;
                spec_lo = '1;
                spec_hi = a;
            end else if (is_signed && a == MOST_NEG && b == '1) begin
                special = 1'b1;
                spec_lo = MOST_NEG;
            end
        end
    end

    muldiv_mstep #(.RV(RV), .MBITS(MBITS)) u_mstep (
        .acc_i   (acc_q),
        .digit_i (opa_q[RV-1 -: MBITS]),
        .bmag_i  (opb_q),
        .acc_o   (acc_d)
    );
    assign mul_res = neg_q ? -acc_d : acc_d;

    // Dividend bits shift out of opa_q MSB-first while quotient bits shift in at the LSB.
    assign rem_sh  = {rem_q, opa_q[RV-1]};
    assign rem_sub = rem_sh - {1'b0, opb_q};
    assign fits    = ~rem_sub[RV];
    assign rem_d   = fits ? rem_sub[RV-1:0] : rem_sh[RV-1:0];
    assign quo_d   = {opa_q[RV-2:0], fits};
    assign quo_fin = neg_q ? -quo_d : quo_d;
    assign rem_fin = rneg_q ? -rem_d : rem_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        if (special) begin
                            done_q <= 1'b1;
                            lo_q   <= spec_lo;
                            hi_q   <= spec_hi;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= is_div ? MD_RUN_DIV : MD_RUN_MUL;
                            cnt_q   <= is_div ? DIV_LAST : MUL_LAST;
                            opa_q   <= a_abs;
                            opb_q   <= b_abs;
                            acc_q   <= '0;
                            rem_q   <= '0;
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                        end
                    end else if (hi_we && !start && !done_q) begin
                        hi_q <= hi_wdata;
                    end
                end
                MD_RUN_MUL: begin
                    if (abort) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        opa_q <= opa_q << MBITS;
                        if (cnt_q == '0) begin
                            state_q      <= MD_IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            {hi_q, lo_q} <= mul_res;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                MD_RUN_DIV: begin
                    if (abort) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        opa_q <= quo_d;
                        if (cnt_q == '0) begin
                            state_q <= MD_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            lo_q    <= quo_fin;
                            hi_q    <= rem_fin;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= MD_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit that sits beside the execute stage. It is the parametrised successor of the 1-bit-per-cycle shift-add multiplier.
- Multiply retires MBITS bits per cycle, selectable at build time.
- Adds signed multiply, plus unsigned and signed restoring divide with remainder.
- Adds a clean abort path for traps and interrupts.
- Results appear on hi/lo registers read by the register file; hi is also software-writable so context can be restored.

Parameters:
RV, 32, datapath width (16 or 32).
MBITS, 1, multiply bits retired per cycle (1, 2 or 4; must divide RV).
DIV, 1, 1 = divide hardware present; 0 = divide ops return zeros.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  command valid; accepted only when busy=0
op  in  2  00 MULU, 01 MULS (signed x signed), 10 DIVU, 11 DIVS
a  in  RV  multiplicand / dividend, sampled at accept
b  in  RV  multiplier / divisor, sampled at accept
abort  in  1  cancel the operation in flight
hi_we  in  1  software write of hi
hi_wdata  in  RV  data for hi_we
busy  out  1  operation in flight
done  out  1  one-cycle pulse; lo/hi valid from this cycle
lo  out  RV  low product / quotient
hi  out  RV  high product / remainder

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: busy=0, done=0, lo=0, hi=0, FSM state IDLE, iteration counter 0. Reset mid-operation discards all work.
- FSM states:
  - IDLE, then RUN_MUL or RUN_DIV on start.
  - RUN_MUL/RUN_DIV return to IDLE when counter==0 or on abort.
- Accept: start && !busy in cycle S. Operands are latched into internal accumulators. For signed ops the absolute values are latched, and the result sign flags are stored.
- Latency:
  - Multiply: N=RV/MBITS iterations in cycles S+1..S+N.
  - Divide: N=RV iterations.
  - busy=1 in cycles S+1..S+N. In cycle S+N+1: busy=0, done=1, lo/hi updated. Back-to-back start is allowed in that cycle.
- Multiply step: acc = (acc << MBITS) + (MBITS-bit digit of |a|, MSB first) * |b|, over a 2RV-bit accumulator.
- Final fixup for multiply: if MULS and the signs differ, the 2RV result is two's-complement negated before loading {hi,lo}.
- Divide: restoring, one bit per cycle, over a partial remainder of RV+1 bits.
- Divide result signs (DIVS): quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Special cases, detected at accept; these complete with done at S+1 and busy is never asserted:
  - Divide by zero: lo = all ones, hi = a.
  - DIVS of (most-negative)/(-1): lo = most-negative, hi = 0.
  - DIV=0 with a divide op: lo = hi = 0.
- lo/hi change only on done, reset, or hi_we. The internal accumulator is separate from them, so abort leaves lo/hi holding their previous values.
- start while busy: ignored, no queueing.
- abort: while busy, returns to IDLE next cycle; busy=0 and no done. Abort in the final iteration cycle also suppresses done. Abort while idle has no effect. Abort in the same cycle as an accepting start cancels that start.
- hi_we:
  - Idle: loads hi next cycle; lo is unchanged.
  - Ignored while busy, and ignored in a cycle where done is being produced.
  - start && hi_we in the same idle cycle: start wins and hi_we is dropped.
- Width rules: all arithmetic is modulo 2RV (multiply) or RV (divide); there are no saturation paths.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MULU=0, MD_MULS=1, MD_DIVU=2, MD_DIVS=3;
  - FSM state encodings;
  - counter width $clog2(RV).
- Sub-module muldiv_mstep: combinational MBITS-digit partial-product add (acc, digit, |b| in; next acc out).
- The FSM, the divide step and the sign fixup stay in the top level.

Test Plan:
- RV=32, MBITS=1, MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at S+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
- MULS a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then MBITS=4 build, MULU 0x10000*0x10000 -> hi=1, lo=0, done at S+9.
- DIVS a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done at S+33; DIVU 100/7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> done at S+1, lo=0xFFFFFFFF, hi=0x1234; DIVS 0x80000000/0xFFFFFFFF -> done at S+1, lo=0x80000000, hi=0.
- Prior lo=0x11, hi=0x22; MULU started, abort at S+10 -> busy=0 at S+11, no done, lo/hi still 0x11/0x22; new start at S+11 completes normally.
- Idle hi_we with 0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, lo unchanged; hi_we during busy -> ignored; start+hi_we in the same cycle -> op runs, hi not written; reset at S+5 -> busy=0, lo=hi=0 next cycle.
